reel_controller: RTL and testbench
==================================

// Module: reel_controller
// PURPOSE
//   Three-reel slot-machine game core, directly downstream of the clock divider.
//   Consumes the divider's toggling changeClk output as a reel-step tick, and the
//   player spin/stop buttons (already debounced, level).
//   Produces reel symbols, per-reel spinning flags, win class and credit count
//   for the display/scoring stages. All logic runs on the single system clock;
//   changeClk is sampled as data, never used as a clock.
// PARAMETERS
//   NUM_SYMBOLS   6   symbols per reel, values 0..NUM_SYMBOLS-1
//   SYM_W         3   symbol width, >= clog2(NUM_SYMBOLS)
//   AUTO_STOP     40  ticks without a stop press before the next reel auto-stops
//   INIT_CREDITS  10  credits after reset
//   MAX_CREDITS   99  credit saturation value (2-digit 7-seg)
//   PAY_PAIR      2   credits paid when exactly two reels match
//   PAY_TRIPLE    10  credits paid when all three reels match
// PORTS
//   clk        in   1      system clock
//   rst        in   1      asynchronous, active-low reset (0 = reset)
//   change_clk in   1      divider toggle output; each rising level = one step tick
//   spin       in   1      spin button, level
//   stop       in   1      stop button, level
//   reel0      out  SYM_W  reel 0 symbol
//   reel1      out  SYM_W  reel 1 symbol
//   reel2      out  SYM_W  reel 2 symbol
//   spinning   out  3      bit i = reel i spinning
//   win        out  2      00 none, 01 pair, 10 triple; valid in RESULT
//   credits    out  7      credit balance
//   busy       out  1      1 in SPIN or EVAL
// BEHAVIOUR
// - Reset (rst=0, async):
//   - state=IDLE; reels=0; spinning=000; win=00; credits=INIT_CREDITS.
//   - Auto counter=0; change_prev=0; spin_prev=1 and stop_prev=1 (no spurious
//     press at release).
// - Edge detect, each signal registered every clk:
//   - tick = change_clk & ~change_prev
//   - spin_e = spin & ~spin_prev
//   - stop_e = stop & ~stop_prev
//   A held button gives exactly one event.
// - States: IDLE, SPIN, EVAL, RESULT.
// - IDLE/RESULT:
//   - spin_e with credits>0: next state SPIN, credits-1, spinning=111, win=00,
//     auto counter=0, all in the same edge.
//   - spin_e with credits=0: ignored, nothing changes.
//   - stop_e: ignored.
// - SPIN:
//   - On a tick cycle, every reel whose spinning bit is 1 does
//     reel <= (reel==NUM_SYMBOLS-1) ? 0 : reel+1.
//   - A stop event (stop_e, or auto counter reaching AUTO_STOP on a tick) clears
//     the lowest set spinning bit (reel0, then 1, then 2) and zeroes the counter.
//   - A reel stopped in a given cycle does not advance in that cycle, even if a
//     tick coincides.
//   - stop_e and auto-expiry in the same cycle stop only one reel.
//   - Auto counter increments on every tick.
//   - spin_e is ignored.
//   - When spinning becomes 000, next state EVAL.
// - EVAL (exactly 1 cycle):
//   - win=10 if r0==r1==r2; else 01 if any pair is equal; else 00.
//   - credits += payout, saturating at MAX_CREDITS.
//   - Next state RESULT.
// - Latency: stop_e to spinning bit clear = 1 clk; last stop to win/credits
//   valid = 2 clk.
// - Reels hold their values in IDLE/RESULT. A new spin starts from the held
//   values.
// - Reset mid-spin aborts immediately to reset values. The spent credit is not
//   refunded.
// TESTING
// - Reset: rst=0 with random inputs -> reels 0/0/0, spinning=000, win=00,
//   credits=10, busy=0. Release with spin held high -> no spin starts.
// - Triple: spin, then 3 separated stop presses with no change_clk edges ->
//   reels 0/0/0, win=10, credits=10-1+10=19, RESULT 2 clk after the 3rd stop.
// - Pair: spin, 1 tick, stop, stop, 1 tick, stop -> reels 1/1/2, win=01,
//   credits 9+2=11.
// - Wrap/auto-stop: spin, 40 ticks with no presses -> reel0 stops at 40 mod 6 = 4
//   and the counter restarts. Total 120 ticks -> all reels stopped, EVAL runs.
// - Credits: drain to 0 -> spin ignored, state stays IDLE. Preload 95 and hit a
//   triple -> credits=99 (saturated).
// - Corner cases:
//   - stop_e coinciding with a tick -> that reel holds its value and the others
//     advance.
//   - rst=0 mid-SPIN -> all outputs at reset values asynchronously, before the
//     next clk edge.

Source files
------------

// File: rtl/reel_controller_if.sv
// Bundle of the game-core I/O: step tick and buttons in, reel/score state out.
// The slave modport is the controller side, the master modport the driving side.
interface reel_controller_if #(
   parameter int SYM_W = 3
);
   logic             change_clk;
   logic             spin;
   logic             stop;
   logic [SYM_W-1:0] reel0;
   logic [SYM_W-1:0] reel1;
   logic [SYM_W-1:0] reel2;
   logic [2:0]       spinning;
   logic [1:0]       win;
   logic [6:0]       credits;
   logic             busy;

   modport master (
      output change_clk, spin, stop,
      input  reel0, reel1, reel2, spinning, win, credits, busy
   );

   modport slave (
      input  change_clk, spin, stop,
      output reel0, reel1, reel2, spinning, win, credits, busy
   );
endinterface

// File: rtl/reel_controller.sv
// Three-reel slot-machine core: reels step on rising change_clk levels, stop on
// button presses or an auto-stop timeout, and the result is scored into credits.
module reel_controller #(
   parameter int NUM_SYMBOLS  = 6,
   parameter int SYM_W        = 3,
   parameter int AUTO_STOP    = 40,
   parameter int INIT_CREDITS = 10,
   parameter int MAX_CREDITS  = 99,
   parameter int PAY_PAIR     = 2,
   parameter int PAY_TRIPLE   = 10
) (
   input logic              clk,
   input logic              rst,
   reel_controller_if.slave bus
);

   localparam int CNT_W = $clog2(AUTO_STOP + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SPIN   = 2'd1,
      EVAL   = 2'd2,
      RESULT = 2'd3
   } state_t;

   state_t           state_r;
   logic [SYM_W-1:0] reel_r [3];
   logic [2:0]       spinning_r;
   logic [1:0]       win_r;
   logic [6:0]       credits_r;
   logic             busy_r;
   logic [CNT_W-1:0] auto_cnt_r;
   logic             change_prev_r;
   logic             spin_prev_r;
   logic             stop_prev_r;

   logic             tick_s;
   logic             spin_e_s;
   logic             stop_e_s;
   logic             stop_req_s;
   logic [2:0]       stop_mask_s;
   logic [2:0]       spin_next_s;
   logic [1:0]       win_s;
   logic [6:0]       pay_s;
   logic [7:0]       credit_sum_s;
   logic [6:0]       credit_eval_s;

   function automatic logic [SYM_W-1:0] next_symbol(input logic [SYM_W-1:0] sym);
      if (sym == SYM_W'(NUM_SYMBOLS - 1)) begin
         return '0;
      end else begin
         return sym + SYM_W'(1);
      end
   endfunction

   function automatic logic [1:0] win_class(input logic [SYM_W-1:0] a,
                                            input logic [SYM_W-1:0] b,
                                            input logic [SYM_W-1:0] c);
      if ((a == b) && (b == c)) begin
         return 2'b10;
      end else if ((a == b) || (b == c) || (a == c)) begin
         return 2'b01;
      end else begin
         return 2'b00;
      end
   endfunction

   assign tick_s     = bus.change_clk & ~change_prev_r;
   assign spin_e_s   = bus.spin & ~spin_prev_r;
   assign stop_e_s   = bus.stop & ~stop_prev_r;
   // A press and an auto-expiry in the same cycle merge into a single stop request.
   assign stop_req_s = stop_e_s | (auto_cnt_r == CNT_W'(AUTO_STOP));

   // Select the lowest still-spinning reel to stop this cycle.
   always_comb begin
      stop_mask_s = 3'b000;
      if (!stop_req_s) begin
         stop_mask_s = 3'b000;
      end else if (spinning_r[0]) begin
         stop_mask_s = 3'b001;
      end else if (spinning_r[1]) begin
         stop_mask_s = 3'b010;
      end else if (spinning_r[2]) begin
         stop_mask_s = 3'b100;
      end else begin
         stop_mask_s = 3'b000;
      end
      spin_next_s = spinning_r & ~stop_mask_s;
   end

   // Score the final reel positions and compute the saturated new balance.
   always_comb begin
      win_s = win_class(reel_r[0], reel_r[1], reel_r[2]);
      case (win_s)
         2'b10:   pay_s = 7'(PAY_TRIPLE);
         2'b01:   pay_s = 7'(PAY_PAIR);
         default: pay_s = 7'd0;
      endcase
      credit_sum_s = {1'b0, credits_r} + {1'b0, pay_s};
      if (credit_sum_s > 8'(MAX_CREDITS)) begin
         credit_eval_s = 7'(MAX_CREDITS);
      end else begin
         credit_eval_s = credit_sum_s[6:0];
      end
   end

   // Game state machine with edge-detect history and all registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= IDLE;
         for (int i = 0; i < 3; i++) begin
            reel_r[i] <= '0;
         end
         spinning_r    <= 3'b000;
         win_r         <= 2'b00;
         credits_r     <= 7'(INIT_CREDITS);
         busy_r        <= 1'b0;
         auto_cnt_r    <= '0;
         change_prev_r <= 1'b0;
         spin_prev_r   <= 1'b1;
         stop_prev_r   <= 1'b1;
      end else begin
         change_prev_r <= bus.change_clk;
         spin_prev_r   <= bus.spin;
         stop_prev_r   <= bus.stop;
         case (state_r)
            IDLE, RESULT: begin
               if (spin_e_s && (credits_r != 7'd0)) begin
                  state_r    <= SPIN;
                  credits_r  <= credits_r - 7'd1;
                  spinning_r <= 3'b111;
                  win_r      <= 2'b00;
                  auto_cnt_r <= '0;
                  busy_r     <= 1'b1;
               end
            end
            SPIN: begin
               for (int i = 0; i < 3; i++) begin
                  if (tick_s && spin_next_s[i]) begin
                     reel_r[i] <= next_symbol(reel_r[i]);
                  end
               end
               spinning_r <= spin_next_s;
               if (stop_req_s) begin
                  auto_cnt_r <= '0;
               end else if (tick_s) begin
                  auto_cnt_r <= auto_cnt_r + CNT_W'(1);
               end
               if (spin_next_s == 3'b000) begin
                  state_r <= EVAL;
               end
            end
            EVAL: begin
               win_r     <= win_s;
               credits_r <= credit_eval_s;
               busy_r    <= 1'b0;
               state_r   <= RESULT;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.reel0    = reel_r[0];
   assign bus.reel1    = reel_r[1];
   assign bus.reel2    = reel_r[2];
   assign bus.spinning = spinning_r;
   assign bus.win      = win_r;
   assign bus.credits  = credits_r;
   assign bus.busy     = busy_r;

endmodule

// File: tb/tb_reel_controller.sv
// Directed bench for reel_controller: expected game results are queued at
// stimulus time and checked by a monitor whenever a game finishes.
module tb_reel_controller;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   reel_controller_if #(.SYM_W(3)) bus ();

   reel_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [2:0] r0;
      logic [2:0] r1;
      logic [2:0] r2;
      logic [1:0] win;
      logic [6:0] cr;
   } res_t;

   res_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   logic busy_q = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_exp(input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] r2,
                           input logic [1:0] w, input logic [6:0] cr);
      res_t e;
      e.r0 = r0; e.r1 = r1; e.r2 = r2; e.win = w; e.cr = cr;
      exp_q.push_back(e);
   endtask

   task automatic press_spin();
      bus.spin = 1'b1; cyc(2); bus.spin = 1'b0; cyc(1);
   endtask

   task automatic press_stop();
      bus.stop = 1'b1; cyc(2); bus.stop = 1'b0; cyc(1);
   endtask

   task automatic tick();
      bus.change_clk = 1'b1; cyc(1); bus.change_clk = 1'b0; cyc(1);
   endtask

   task automatic do_reset();
      rst = 1'b0; cyc(3); rst = 1'b1; cyc(2);
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (bus.busy && (k < 400)) begin
         cyc(1);
         k++;
      end
      chk(name, {31'd0, bus.busy}, 32'd0);
      cyc(2);
   endtask

   // Monitor: a busy falling edge outside reset marks a finished game result.
   always @(negedge clk) begin
      res_t e;
      if (!rst) begin
         busy_q = 1'b0;
      end else begin
         if (busy_q && !bus.busy) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_result: got credits %0d, expected no result", bus.credits);
            end else begin
               e = exp_q.pop_front();
               chk("res_reel0", 32'(bus.reel0), 32'(e.r0));
               chk("res_reel1", 32'(bus.reel1), 32'(e.r1));
               chk("res_reel2", 32'(bus.reel2), 32'(e.r2));
               chk("res_win", 32'(bus.win), 32'(e.win));
               chk("res_credits", 32'(bus.credits), 32'(e.cr));
            end
         end
         busy_q = bus.busy;
      end
   end

   initial begin
      int cr;
      bus.change_clk = 1'b0;
      bus.spin       = 1'b0;
      bus.stop       = 1'b0;

      // Reset with random inputs, then release while buttons are held.
      for (int i = 0; i < 4; i++) begin
         bus.change_clk = 1'($urandom);
         bus.spin       = 1'($urandom);
         bus.stop       = 1'($urandom);
         cyc(1);
      end
      chk("rst_reel0", 32'(bus.reel0), 32'd0);
      chk("rst_reel1", 32'(bus.reel1), 32'd0);
      chk("rst_reel2", 32'(bus.reel2), 32'd0);
      chk("rst_spinning", 32'(bus.spinning), 32'd0);
      chk("rst_win", 32'(bus.win), 32'd0);
      chk("rst_credits", 32'(bus.credits), 32'd10);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      bus.spin = 1'b1; bus.stop = 1'b1; bus.change_clk = 1'b0;
      rst = 1'b1;
      cyc(4);
      chk("held_spin_busy", 32'(bus.busy), 32'd0);
      chk("held_spin_credits", 32'(bus.credits), 32'd10);
      bus.spin = 1'b0; bus.stop = 1'b0;
      cyc(2);

      // Triple with no ticks, including stop-to-result latency.
      push_exp(3'd0, 3'd0, 3'd0, 2'b10, 7'd19);
      press_spin();
      chk("spin_busy", 32'(bus.busy), 32'd1);
      chk("spin_spinning", 32'(bus.spinning), 32'd7);
      chk("spin_credits", 32'(bus.credits), 32'd9);
      press_stop();
      press_stop();
      chk("two_stops_spinning", 32'(bus.spinning), 32'd4);
      bus.stop = 1'b1; cyc(1);
      chk("last_stop_spinning", 32'(bus.spinning), 32'd0);
      chk("eval_busy", 32'(bus.busy), 32'd1);
      cyc(1);
      chk("result_busy", 32'(bus.busy), 32'd0);
      chk("result_win", 32'(bus.win), 32'd2);
      bus.stop = 1'b0; cyc(2);

      // Repeated triples climb 9 per game and saturate at 99.
      cr = 19;
      for (int g = 0; g < 10; g++) begin
         cr = cr - 1 + 10;
         if (cr > 99) cr = 99;
         push_exp(3'd0, 3'd0, 3'd0, 2'b10, 7'(cr));
         press_spin();
         press_stop();
         press_stop();
         press_stop();
         wait_idle("triple_timeout");
      end
      chk("saturated_credits", 32'(bus.credits), 32'd99);

      // Pair: reels 1/1/2.
      do_reset();
      push_exp(3'd1, 3'd1, 3'd2, 2'b01, 7'd11);
      press_spin();
      tick();
      press_stop();
      press_stop();
      tick();
      press_stop();
      wait_idle("pair_timeout");

      // Stop coinciding with a tick: stopped reel holds, others advance.
      do_reset();
      push_exp(3'd0, 3'd2, 3'd2, 2'b01, 7'd11);
      press_spin();
      bus.stop = 1'b1; bus.change_clk = 1'b1; cyc(1);
      bus.change_clk = 1'b0; cyc(1);
      bus.stop = 1'b0; cyc(1);
      chk("coinc_spinning", 32'(bus.spinning), 32'd6);
      chk("coinc_reel0", 32'(bus.reel0), 32'd0);
      chk("coinc_reel1", 32'(bus.reel1), 32'd1);
      tick();
      press_stop();
      press_stop();
      wait_idle("coinc_timeout");

      // Auto-stop after 40 ticks per reel; reels end at 4/2/0.
      do_reset();
      push_exp(3'd4, 3'd2, 3'd0, 2'b00, 7'd9);
      press_spin();
      repeat (40) tick();
      chk("auto_spinning_1", 32'(bus.spinning), 32'd6);
      chk("auto_reel0", 32'(bus.reel0), 32'd4);
      chk("auto_reel1_mid", 32'(bus.reel1), 32'd4);
      repeat (79) tick();
      chk("auto_spinning_119", 32'(bus.spinning), 32'd4);
      tick();
      wait_idle("auto_timeout");

      // Drain credits with losing games, then a spin must be ignored.
      do_reset();
      push_exp(3'd1, 3'd2, 3'd3, 2'b00, 7'd9);
      press_spin();
      tick(); press_stop();
      tick(); press_stop();
      tick(); press_stop();
      wait_idle("drain_first_timeout");
      for (int g = 8; g >= 0; g--) begin
         push_exp(3'd1, 3'd2, 3'd3, 2'b00, 7'(g));
         press_spin();
         press_stop();
         press_stop();
         press_stop();
         wait_idle("drain_timeout");
      end
      press_spin();
      cyc(2);
      chk("zero_credit_busy", 32'(bus.busy), 32'd0);
      chk("zero_credit_spinning", 32'(bus.spinning), 32'd0);
      chk("zero_credit_credits", 32'(bus.credits), 32'd0);

      // Asynchronous reset in the middle of a spin.
      do_reset();
      press_spin();
      tick();
      tick();
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_reel0", 32'(bus.reel0), 32'd0);
      chk("async_reel2", 32'(bus.reel2), 32'd0);
      chk("async_spinning", 32'(bus.spinning), 32'd0);
      chk("async_win", 32'(bus.win), 32'd0);
      chk("async_credits", 32'(bus.credits), 32'd10);
      chk("async_busy", 32'(bus.busy), 32'd0);
      cyc(2);
      rst = 1'b1;
      cyc(5);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
